// File: rtl/alu_writeback.sv
// alu_writeback: ALU result writeback sequencer and F register holder
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid / in_ready       : ALU transfer handshake
//   result, flag_in, flag_mask: ALU result, flags and per-bit F update mask
//   wide, wb_en, dest_reg     : 16-bit pair write, write enable, destination byte register
//   f_load, f_load_data       : direct F load (POP AF), wins over the flag update
//   rf_we, rf_waddr, rf_wdata : registered single byte-wide register-file write port
//   f_reg, cin                : current F and its carry bit fed back to the ALU
//   busy                      : high while a write is being presented
module alu_writeback #(
  parameter int          RF_ADDR_W   = 3,
  parameter logic [7:0]  F_RESET     = 8'h00,
  parameter logic [7:0]  F_IMPL_MASK = 8'hC7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          result,
  input  logic [7:0]           flag_in,
  input  logic [7:0]           flag_mask,
  input  logic                 wide,
  input  logic                 wb_en,
  input  logic [RF_ADDR_W-1:0] dest_reg,
  input  logic                 f_load,
  input  logic [7:0]           f_load_data,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [7:0]           rf_wdata,
  output logic [7:0]           f_reg,
  output logic                 cin,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, WR_HI, WR_LO} state_t;
  state_t                 state_q, state_d;
  logic                   accept;
  logic [7:0]             m, f_q, f_d;
  logic [15:0]            res_q, res_d;
  logic [RF_ADDR_W-1:0]   dest_q, dest_d, rf_waddr_q, rf_waddr_d;
  logic                   wide_q, wide_d, rf_we_q;
  logic [7:0]             rf_wdata_q, rf_wdata_d;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    accept  = in_valid & in_ready;
    state_d = accept ? (!wb_en ? IDLE : wide ? WR_HI : WR_LO)
                     : (state_q == WR_HI ? WR_LO : IDLE);
  end
  always_comb begin
    in_ready = (state_q == IDLE) | (state_q == WR_LO);
    busy     = state_q != IDLE;
  end
  // Capture happens on the accept edge; the outputs for the upcoming write
  // are computed from the post-capture view so they can be registered.
  always_comb begin
    m          = flag_mask & F_IMPL_MASK;
    f_d        = f_load ? (f_load_data & F_IMPL_MASK)
               : accept ? ((f_q & ~m) | (flag_in & m)) : f_q;
    res_d      = accept ? result : res_q;
    wide_d     = accept ? wide : wide_q;
    dest_d     = accept ? (wide ? {dest_reg[RF_ADDR_W-1:1], 1'b0} : dest_reg) : dest_q;
    rf_waddr_d = state_d == WR_HI ? dest_d
               : state_d == WR_LO ? (wide_d ? {dest_d[RF_ADDR_W-1:1], 1'b1} : dest_d)
               : '0;
    rf_wdata_d = state_d == WR_HI ? res_d[15:8] : state_d == WR_LO ? res_d[7:0] : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q        <= F_RESET & F_IMPL_MASK;
      res_q      <= '0;
      dest_q     <= '0;
      wide_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      f_q        <= f_d;
      res_q      <= res_d;
      dest_q     <= dest_d;
      wide_q     <= wide_d;
      rf_we_q    <= state_d != IDLE;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign f_reg    = f_q;
  assign cin      = f_q[0];
endmodule
